// File: rtl/dm_wb_cache_param.sv
// rtl/dm_wb_cache_param.sv - parametrised direct-mapped write-back cache
// Defining CACHE_FLUSH_EN adds the flush/flush_done whole-cache write-back scan.
module dm_wb_cache_param #(
    parameter int ADDR_W         = 27,
    parameter int WORD_W         = 32,
    parameter int INDEX_W        = 10,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [WORD_W-1:0]                write_data,
    input  logic                             write,
    input  logic                             enable,
`ifdef CACHE_FLUSH_EN
    input  logic                             flush,
    output logic                             flush_done,
`endif
    output logic [WORD_W-1:0]                read_data,
    output logic                             available,
    output logic [ADDR_W-1:0]                ddr2_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0] to_ddr2_data,
    output logic                             ddr2_enable,
    output logic                             ddr2_read,
    input  logic                             ddr2_available,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] ddr2_data
);
    localparam int OFFS_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFS_W - 2;
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int LINES  = 1 << INDEX_W;
    localparam logic [OFFS_W+1:0] ZERO_LO = '0;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_WAIT,
        FILL,
        RESP
`ifdef CACHE_FLUSH_EN
        ,
        FLUSH_SCAN
`endif
    } state_t;

    state_t state;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    logic [OFFS_W-1:0]  a_sel;
    logic [INDEX_W-1:0] a_idx;
    logic [TAG_W-1:0]   a_tag;
    logic               hit;
    logic [LINE_W-1:0]  hit_line;
    logic [WORD_W-1:0]  hit_word;
    logic               unused_addr_lsb;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [OFFS_W-1:0]  req_sel;
    logic [WORD_W-1:0]  req_wdata;
    logic               req_write;
    logic [LINE_W-1:0]  fill_line;

    logic               mem_we;
    logic [INDEX_W-1:0] mem_idx;
    logic [TAG_W-1:0]   mem_tag;
    logic [LINE_W-1:0]  mem_line;
    logic [INDEX_W-1:0] wb_idx;

`ifdef CACHE_FLUSH_EN
    logic [INDEX_W-1:0] flush_idx;
    logic               flushing;
`endif

    assign a_sel           = addr[OFFS_W+1:2];
    assign a_idx           = addr[INDEX_W+OFFS_W+1:OFFS_W+2];
    assign a_tag           = addr[ADDR_W-1:INDEX_W+OFFS_W+2];
    assign unused_addr_lsb = ^addr[1:0];
    assign hit             = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign hit_line        = data_mem[a_idx];
    assign hit_word        = hit_line[a_sel*WORD_W +: WORD_W];

`ifdef CACHE_FLUSH_EN
    assign wb_idx = flushing ? flush_idx : req_idx;
`else
    assign wb_idx = req_idx;
`endif

    // Single write port: either a store hit in IDLE or the refill install in FILL.
    always_comb begin
        mem_we   = 1'b0;
        mem_idx  = a_idx;
        mem_tag  = a_tag;
        mem_line = hit_line;
        if (state == IDLE && enable && hit && write) begin
            mem_we = 1'b1;
            mem_line[a_sel*WORD_W +: WORD_W] = write_data;
        end else if (state == FILL) begin
            mem_we   = 1'b1;
            mem_idx  = req_idx;
            mem_tag  = req_tag;
            mem_line = fill_line;
            if (req_write) begin
                mem_line[req_sel*WORD_W +: WORD_W] = req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            tag_mem[mem_idx]  <= mem_tag;
            data_mem[mem_idx] <= mem_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            read_data    <= '0;
            available    <= 1'b0;
            ddr2_addr    <= '0;
            to_ddr2_data <= '0;
            ddr2_enable  <= 1'b0;
            ddr2_read    <= 1'b0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_sel      <= '0;
            req_wdata    <= '0;
            req_write    <= 1'b0;
            fill_line    <= '0;
`ifdef CACHE_FLUSH_EN
            flush_done   <= 1'b0;
            flush_idx    <= '0;
            flushing     <= 1'b0;
`endif
        end else begin
            available   <= 1'b0;
            ddr2_enable <= 1'b0;
`ifdef CACHE_FLUSH_EN
            flush_done  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (hit) begin
                            available <= 1'b1;
                            read_data <= write ? write_data : hit_word;
                            if (write) begin
                                dirty[a_idx] <= 1'b1;
                            end
                            state <= RESP;
                        end else begin
                            req_tag     <= a_tag;
                            req_idx     <= a_idx;
                            req_sel     <= a_sel;
                            req_wdata   <= write_data;
                            req_write   <= write;
                            ddr2_enable <= 1'b1;
                            if (valid[a_idx] && dirty[a_idx]) begin
                                ddr2_read    <= 1'b0;
                                ddr2_addr    <= {tag_mem[a_idx], a_idx, ZERO_LO};
                                to_ddr2_data <= hit_line;
                                state        <= WB_REQ;
                            end else begin
                                ddr2_read <= 1'b1;
                                ddr2_addr <= {a_tag, a_idx, ZERO_LO};
                                state     <= RF_REQ;
                            end
                        end
                    end
`ifdef CACHE_FLUSH_EN
                    else if (flush) begin
                        flush_idx <= '0;
                        flushing  <= 1'b1;
                        state     <= FLUSH_SCAN;
                    end
`endif
                end
                WB_REQ: state <= WB_WAIT;
                WB_WAIT: begin
                    if (ddr2_available) begin
                        dirty[wb_idx] <= 1'b0;
`ifdef CACHE_FLUSH_EN
                        // Revisit the same index; it is now clean and the scan advances.
                        if (flushing) begin
                            state <= FLUSH_SCAN;
                        end else
`endif
                        begin
                            ddr2_enable <= 1'b1;
                            ddr2_read   <= 1'b1;
                            ddr2_addr   <= {req_tag, req_idx, ZERO_LO};
                            state       <= RF_REQ;
                        end
                    end
                end
                RF_REQ: state <= RF_WAIT;
                RF_WAIT: begin
                    if (ddr2_available) begin
                        fill_line <= ddr2_data;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    valid[req_idx] <= 1'b1;
                    dirty[req_idx] <= req_write;
                    available      <= 1'b1;
                    read_data      <= mem_line[req_sel*WORD_W +: WORD_W];
                    state          <= RESP;
                end
                RESP: state <= IDLE;
`ifdef CACHE_FLUSH_EN
                FLUSH_SCAN: begin
                    if (valid[flush_idx] && dirty[flush_idx]) begin
                        ddr2_enable  <= 1'b1;
                        ddr2_read    <= 1'b0;
                        ddr2_addr    <= {tag_mem[flush_idx], flush_idx, ZERO_LO};
                        to_ddr2_data <= data_mem[flush_idx];
                        state        <= WB_REQ;
                    end else if (flush_idx == {INDEX_W{1'b1}}) begin
                        flush_done <= 1'b1;
                        flushing   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        flush_idx <= flush_idx + {{(INDEX_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_wb_cache_param.sv
// tb/tb_dm_wb_cache_param.sv - directed bench for dm_wb_cache_param
module tb_dm_wb_cache_param;
    logic         clk = 1'b0;
    logic         rst;
    logic [26:0]  addr;
    logic [31:0]  write_data;
    logic         write;
    logic         enable;
    logic [31:0]  read_data;
    logic         available;
    logic [26:0]  ddr2_addr;
    logic [127:0] to_ddr2_data;
    logic         ddr2_enable;
    logic         ddr2_read;
    logic         ddr2_available;
    logic [127:0] ddr2_data;
`ifdef CACHE_FLUSH_EN
    logic         flush;
    logic         flush_done;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int ddr_cmds    = 0;
    int consec      = 0;
    logic prev_en   = 1'b0;

    dm_wb_cache_param dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .write_data    (write_data),
        .write         (write),
        .enable        (enable),
`ifdef CACHE_FLUSH_EN
        .flush         (flush),
        .flush_done    (flush_done),
`endif
        .read_data     (read_data),
        .available     (available),
        .ddr2_addr     (ddr2_addr),
        .to_ddr2_data  (to_ddr2_data),
        .ddr2_enable   (ddr2_enable),
        .ddr2_read     (ddr2_read),
        .ddr2_available(ddr2_available),
        .ddr2_data     (ddr2_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ddr2_enable === 1'b1) begin
            ddr_cmds = ddr_cmds + 1;
            if (prev_en) consec = consec + 1;
        end
        prev_en = (ddr2_enable === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hit_txn(input string tag, input logic [26:0] a, input logic wr,
                           input logic [31:0] wd, input logic [31:0] exp_word);
        int c0;
        c0 = ddr_cmds;
        addr = a; write = wr; write_data = wd; enable = 1'b1;
        step();
        enable = 1'b0;
        chk({tag, "_avail"}, available, 1);
        chk({tag, "_data"}, read_data, exp_word);
        chk({tag, "_no_ddr"}, ddr2_enable, 0);
        step();
        chk({tag, "_avail_end"}, available, 0);
        chk({tag, "_cmds"}, ddr_cmds, c0);
    endtask

    task automatic miss_txn(input string tag, input logic [26:0] a, input logic wr,
                            input logic [31:0] wd, input logic wb, input logic [26:0] wb_a,
                            input logic [127:0] wb_d, input logic [127:0] refill,
                            input logic [31:0] exp_word);
        addr = a; write = wr; write_data = wd; enable = 1'b1;
        step();
        enable = 1'b0;
        if (wb) begin
            chk({tag, "_wb_en"}, ddr2_enable, 1);
            chk({tag, "_wb_rd"}, ddr2_read, 0);
            chk({tag, "_wb_addr"}, ddr2_addr, wb_a);
            chk({tag, "_wb_data"}, to_ddr2_data, wb_d);
            step();
            chk({tag, "_wb_hold_en"}, ddr2_enable, 0);
            chk({tag, "_wb_hold_addr"}, ddr2_addr, wb_a);
            ddr2_available = 1'b1;
            step();
            ddr2_available = 1'b0;
        end
        chk({tag, "_rf_en"}, ddr2_enable, 1);
        chk({tag, "_rf_rd"}, ddr2_read, 1);
        chk({tag, "_rf_addr"}, ddr2_addr, {a[26:4], 4'h0});
        step();
        ddr2_available = 1'b1; ddr2_data = refill;
        step();
        ddr2_available = 1'b0;
        chk({tag, "_early"}, available, 0);
        step();
        chk({tag, "_avail"}, available, 1);
        chk({tag, "_data"}, read_data, exp_word);
        step();
        chk({tag, "_avail_end"}, available, 0);
    endtask

    initial begin
        rst = 1'b1; addr = '0; write_data = '0; write = 1'b0; enable = 1'b0;
        ddr2_available = 1'b0; ddr2_data = '0;
`ifdef CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        step(); step();
        chk("rst_avail", available, 0);
        chk("rst_ddr_en", ddr2_enable, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_ddr_addr", ddr2_addr, 0);
        chk("rst_ddr_read", ddr2_read, 0);
        rst = 1'b0;
        step();

        miss_txn("rd40", 27'h0000040, 0, 0, 0, 0, 0,
                 128'h44444444_33333333_22222222_11111111, 32'h11111111);
        hit_txn("rd44", 27'h0000044, 0, 0, 32'h22222222);
        hit_txn("wr48", 27'h0000048, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        hit_txn("rd48", 27'h0000048, 0, 0, 32'hDEADBEEF);
        miss_txn("rd4040", 27'h0004040, 0, 0, 1, 27'h0000040,
                 128'h44444444_DEADBEEF_22222222_11111111,
                 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 32'hAAAA0000);
        miss_txn("rd40b", 27'h0000040, 0, 0, 0, 0, 0,
                 128'h44444444_DEADBEEF_22222222_11111111, 32'h11111111);

        // Reset while waiting for a refill; the late reply must be ignored.
        addr = 27'h0008040; write = 1'b0; enable = 1'b1;
        step();
        enable = 1'b0;
        chk("rstmid_rf_en", ddr2_enable, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_addr", ddr2_addr, 0);
        chk("rstmid_read", ddr2_read, 0);
        ddr2_available = 1'b1; ddr2_data = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        step();
        ddr2_available = 1'b0;
        step();
        chk("rstmid_avail", available, 0);
        chk("rstmid_ddr_en", ddr2_enable, 0);
        chk("rstmid_rdata", read_data, 0);
        miss_txn("rd8040", 27'h0008040, 0, 0, 0, 0, 0,
                 128'h00000004_00000003_00000002_00000001, 32'h00000001);
        miss_txn("wrC048", 27'h000C048, 1, 32'hCAFEF00D, 0, 0, 0,
                 128'h88888888_77777777_66666666_55555555, 32'hCAFEF00D);
        hit_txn("rdC044", 27'h000C044, 0, 0, 32'h66666666);
        miss_txn("rd40c", 27'h0000040, 0, 0, 1, 27'h000C040,
                 128'h88888888_CAFEF00D_66666666_55555555,
                 128'h0000000D_0000000C_0000000B_0000000A, 32'h0000000A);

`ifdef CACHE_FLUSH_EN
        begin
            int wbn;
            int resp;
            bit done;
            logic [26:0] wba [4];
            rst = 1'b1;
            step();
            rst = 1'b0;
            miss_txn("fl_w44", 27'h0000044, 1, 32'h12345678, 0, 0, 0,
                     128'h0, 32'h12345678);
            miss_txn("fl_w3ff0", 27'h0003FF0, 1, 32'h87654321, 0, 0, 0,
                     128'h0, 32'h87654321);
            miss_txn("fl_r50", 27'h0000050, 0, 0, 0, 0, 0,
                     128'h5, 32'h00000005);
            wbn = 0; resp = 0; done = 1'b0;
            for (int k = 0; k < 4; k++) wba[k] = '0;
            flush = 1'b1;
            step();
            flush = 1'b0;
            for (int i = 0; i < 3000 && !done; i++) begin
                ddr2_available = (resp == 1);
                if (resp > 0) resp = resp - 1;
                if (ddr2_enable) begin
                    if (wbn < 4) wba[wbn] = ddr2_addr;
                    wbn = wbn + 1;
                    resp = 2;
                end
                if (flush_done) done = 1'b1;
                enable = 1'b1;
                addr = 27'h0000050;
                step();
            end
            enable = 1'b0;
            ddr2_available = 1'b0;
            chk("fl_done", done, 1);
            chk("fl_wb_count", wbn, 2);
            chk("fl_wb0", wba[0], 27'h0000040);
            chk("fl_wb1", wba[1], 27'h0003FF0);
            step();
            hit_txn("fl_rd44", 27'h0000044, 0, 0, 32'h12345678);
        end
`endif

        chk("no_consec_ddr_en", consec, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
